muladd4: RTL and testbench
==========================

// Module: muladd4
// PURPOSE
//   Four-lane pipelined multiply-add. Each cycle, forms four unsigned 16x16 products
//   dataa_i*datab_i and outputs their sum.
//   Used as the dot-product / MAC datapath element between operand registers and accumulator logic.
//   Fully pipelined: accepts new operands every clock, no handshake.
// PARAMETERS
//   A_W    16  width of each dataa_i operand
//   B_W    16  width of each datab_i operand
//   R_W    32  width of result (A_W+B_W)
// PORTS
//   clk       in   1     single clock, all registers on rising edge
//   rst_n     in   1     reset, asynchronous, active-low
//   dataa_0   in   A_W   lane 0 multiplicand
//   dataa_1   in   A_W   lane 1 multiplicand
//   dataa_2   in   A_W   lane 2 multiplicand
//   dataa_3   in   A_W   lane 3 multiplicand
//   datab_0   in   B_W   lane 0 multiplier
//   datab_1   in   B_W   lane 1 multiplier
//   datab_2   in   B_W   lane 2 multiplier
//   datab_3   in   B_W   lane 3 multiplier
//   result    out  R_W   registered sum of the four products
// BEHAVIOUR
//   - Operands: all unsigned.
//   - Pipeline: 3 register stages, latency 3 rising edges, throughput 1/clk.
//     - S1: register all 8 operands.
//     - S2: register four products p_i = a_i*b_i (each R_W bits, exact).
//     - S3: register result = p0+p1+p2+p3.
//   - Sum arithmetic:
//     - Adder tree sums at R_W+2 bits, exact.
//     - Without the optional feature, result = low R_W bits of the sum (modulo 2^32 wrap).
//   - Reset:
//     - rst_n low immediately clears every pipeline register; result=0 asynchronously.
//     - While rst_n is low, inputs are ignored and result stays 0.
//   - Reset release: the first valid result appears 3 edges after the first edge with rst_n high.
//     Earlier outputs are 0 products, i.e. result=0.
//   - Reset mid-operation: all in-flight data discarded; no partial sums survive.
//   - Inputs changing every cycle: each operand set yields exactly its own sum 3 cycles later.
//     No cross-cycle mixing.
//   - No X propagation from reset state; no enable, no stall.
// CONFIGURATION
//   - MULADD4_SATURATE_EN defined:
//     - S3 compares the R_W+2-bit sum against 2^R_W-1.
//     - If larger, result=32'hFFFF_FFFF, otherwise the exact sum.
//     - Latency unchanged.
//   - Not defined: wrap-around truncation as above. No other behaviour differs.
// TESTING
//   1. a=(1,2,3,4), b=(1,1,1,1) held after reset release -> result=10 from 3rd edge on, 0 before.
//   2. All a_i=b_i=16'hFFFF -> wrap build: result=32'hFFF8_0004;
//      MULADD4_SATURATE_EN: result=32'hFFFF_FFFF.
//   3. Stream, new sets on consecutive edges:
//      (a0=b0=2, rest 0) then (a3=b3=100, rest 0) then all 0 -> result 4, 10000, 0 on edges 3, 4, 5.
//   4. rst_n asserted low between edges while data in flight -> result=0 immediately (async);
//      after release, stale data never appears; first new sum after 3 edges.
//   5. a=(16'hFFFF,0,0,0), b=(16'hFFFF,0,0,0) -> result=32'hFFFE_0001 (no overflow, both builds).
//   6. Lane isolation: walk a single nonzero lane i with a_i=3, b_i=7 -> result=21 for each i.

Source files
------------

// File: rtl/muladd4_if.sv
// Operand/result bundle for the muladd4 four-lane multiply-add.
// Parameters: A_W/B_W operand widths, R_W result width (A_W+B_W).
// Signals: dataa_0..3 / datab_0..3 per-lane unsigned operands, result registered sum.
// Modports: master drives operands and observes result; slave is the datapath side.
interface muladd4_if #(
  parameter int A_W = 16,
  parameter int B_W = 16,
  parameter int R_W = 32
);
  logic [A_W-1:0] dataa_0, dataa_1, dataa_2, dataa_3;
  logic [B_W-1:0] datab_0, datab_1, datab_2, datab_3;
  logic [R_W-1:0] result;

  modport master (
    output dataa_0, dataa_1, dataa_2, dataa_3,
    output datab_0, datab_1, datab_2, datab_3,
    input  result
  );

  modport slave (
    input  dataa_0, dataa_1, dataa_2, dataa_3,
    input  datab_0, datab_1, datab_2, datab_3,
    output result
  );
endinterface

// File: rtl/muladd4.sv
// muladd4: four-lane pipelined unsigned multiply-add, result = sum(a_i*b_i).
// Three register stages (operands, products, sum), latency 3, one set per clock.
// Ports: clk rising-edge clock; rst_n async active-low reset clearing every stage;
//        bus (muladd4_if.slave) carries dataa_0..3, datab_0..3 and result.
// Option: define MULADD4_SATURATE_EN to clamp the sum to all-ones instead of
//         wrapping modulo 2^R_W. Latency is the same in both builds.

// One lane: operand register (S1) followed by exact product register (S2).
module muladd4_lane #(
  parameter int A_W = 16,
  parameter int B_W = 16,
  parameter int R_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [R_W-1:0] prod
);
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      prod <= '0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      prod <= R_W'(a_q) * R_W'(b_q);
    end
  end
endmodule

module muladd4 #(
  parameter int A_W = 16,
  parameter int B_W = 16,
  parameter int R_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muladd4_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][A_W-1:0] a;
  logic [NUM_LANES-1:0][B_W-1:0] b;
  logic [NUM_LANES-1:0][R_W-1:0] prod;

  assign a = {bus.dataa_3, bus.dataa_2, bus.dataa_1, bus.dataa_0};
  assign b = {bus.datab_3, bus.datab_2, bus.datab_1, bus.datab_0};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    muladd4_lane #(.A_W(A_W), .B_W(B_W), .R_W(R_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a[i]),
      .b    (b[i]),
      .prod (prod[i])
    );
  end

  // Two-level adder tree, each level one bit wider so the sum is exact.
  logic [R_W:0]   s01, s23;
  logic [R_W+1:0] sum;

  assign s01 = (R_W+1)'(prod[0]) + (R_W+1)'(prod[1]);
  assign s23 = (R_W+1)'(prod[2]) + (R_W+1)'(prod[3]);
  assign sum = (R_W+2)'(s01) + (R_W+2)'(s23);

  logic [R_W-1:0] sum_out;

`ifdef MULADD4_SATURATE_EN
  // Clamp anything that does not fit in R_W bits.
  assign sum_out = (sum > (R_W+2)'({R_W{1'b1}})) ? {R_W{1'b1}} : sum[R_W-1:0];
`else
  // Plain modulo-2^R_W wrap; the carry bits are intentionally dropped.
  logic unused_carry;
  assign unused_carry = ^sum[R_W+1:R_W];
  assign sum_out      = sum[R_W-1:0];
`endif

  logic [R_W-1:0] res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= sum_out;
  end

  assign bus.result = res_q;
endmodule

// File: tb/tb_muladd4.sv
module tb_muladd4;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  muladd4_if #(.A_W(16), .B_W(16), .R_W(32)) bus ();

  muladd4 #(.A_W(16), .B_W(16), .R_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Literal expectation for the next negedge, set by the stimulus process.
  logic        lit_en  = 1'b0;
  logic [31:0] lit_val = '0;
  string       lit_nm  = "";

  // Model: the sum the specification demands for the operands currently applied.
  function automatic logic [31:0] model_sum();
    logic [63:0] s;
    s = 64'(bus.dataa_0) * 64'(bus.datab_0) + 64'(bus.dataa_1) * 64'(bus.datab_1)
      + 64'(bus.dataa_2) * 64'(bus.datab_2) + 64'(bus.dataa_3) * 64'(bus.datab_3);
`ifdef MULADD4_SATURATE_EN
    if (s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return s[31:0];
  endfunction

  // Expected results in order of age: exp_d[0] is what result must show now.
  // Reset discards everything in flight, leaving only zeros.
  logic [31:0] exp_d [3] = '{32'd0, 32'd0, 32'd0};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_d <= '{32'd0, 32'd0, 32'd0};
    else        exp_d <= '{exp_d[1], exp_d[2], model_sum()};
  end

  // Single compare process: model check every cycle, plus literal pins.
  always @(negedge clk) begin
    int c, f;
    c = 1; f = 0;
    if (bus.result !== exp_d[0]) begin
      f++;
      $display("FAIL stream t=%0t got=%h want=%h", $time, bus.result, exp_d[0]);
    end
    if (lit_en) begin
      c += 2;
      if (bus.result !== lit_val) begin
        f++;
        $display("FAIL %s dut got=%h want=%h", lit_nm, bus.result, lit_val);
      end
      if (exp_d[0] !== lit_val) begin
        f++;
        $display("FAIL %s model got=%h want=%h", lit_nm, exp_d[0], lit_val);
      end
    end
    n_cmp <= n_cmp + c;
    n_bad <= n_bad + f;
  end

  task automatic step();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic expect_lit(input string nm, input logic [31:0] v);
    lit_nm  = nm;
    lit_val = v;
    lit_en  = 1'b1;
  endtask

  task automatic drive(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    bus.dataa_0 = a0; bus.dataa_1 = a1; bus.dataa_2 = a2; bus.dataa_3 = a3;
    bus.datab_0 = b0; bus.datab_1 = b1; bus.datab_2 = b2; bus.datab_3 = b3;
  endtask

  // Apply a set, hold it, and pin the result seen on the third edge.
  task automatic hold_and_check(input string nm, input logic [31:0] v);
    step(); step();
    step(); expect_lit(nm, v);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    step(); expect_lit("reset", 32'd0);
    step(); expect_lit("reset_hold", 32'd0);

    // Release with a=(1,2,3,4), b=1: zero for two edges, then 10.
    step(); rst_n = 1'b1; drive(1, 2, 3, 4, 1, 1, 1, 1);
    step(); expect_lit("t1_edge1", 32'd0);
    step(); expect_lit("t1_edge2", 32'd0);
    step(); expect_lit("t1_edge3", 32'd10);
    step(); expect_lit("t1_held", 32'd10);

    // All-ones operands.
    drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
`ifdef MULADD4_SATURATE_EN
    hold_and_check("t2_sat", 32'hFFFF_FFFF);
`else
    hold_and_check("t2_wrap", 32'hFFF8_0004);
`endif

    // Single max lane: no overflow.
    step(); drive(16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    hold_and_check("t5_maxlane", 32'hFFFE_0001);

    // Back-to-back stream.
    step(); drive(2, 0, 0, 0, 2, 0, 0, 0);
    step(); drive(0, 0, 0, 100, 0, 0, 0, 100);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); expect_lit("t3_s1", 32'd4);
    step(); expect_lit("t3_s2", 32'd10000);
    step(); expect_lit("t3_s3", 32'd0);

    // Reset mid-flight: 30 is in the pipe, reset lands between edges.
    step(); drive(5, 0, 0, 0, 6, 0, 0, 0);
    step();
    step(); rst_n = 1'b0; expect_lit("t4_async", 32'd0);
    step(); expect_lit("t4_in_rst", 32'd0);
    step(); rst_n = 1'b1; drive(2, 0, 0, 0, 9, 0, 0, 0);
    step(); expect_lit("t4_edge1", 32'd0);
    step(); expect_lit("t4_edge2", 32'd0);
    step(); expect_lit("t4_edge3", 32'd18);

    // Lane isolation.
    for (int i = 0; i < 4; i++) begin
      step();
      drive(i == 0 ? 3 : 0, i == 1 ? 3 : 0, i == 2 ? 3 : 0, i == 3 ? 3 : 0,
            i == 0 ? 7 : 0, i == 1 ? 7 : 0, i == 2 ? 7 : 0, i == 3 ? 7 : 0);
      hold_and_check($sformatf("t6_lane%0d", i), 32'd21);
    end

    step(); step();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
